// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the iterative AES-128 encryption core:
//   NR          number of rounds for a 128-bit key
//   aes_state_e round sequencer states (IDLE / ROUND / DONE)
//   rcon()      round-constant table RCON[1:10], 0 outside that range
//   xtime(), gf_mul(), sbox(), mix_column()  GF(2^8) helpers
// Byte order everywhere is FIPS-197: bits [127:120] are byte 0.
// ---------------------------------------------------------------------------
package aes_pkg;

   localparam int NR = 10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUND = 2'd1,
      ST_DONE  = 2'd2
   } aes_state_e;

   // RCON[1:10]; any other index yields 0 so an idle round counter is harmless.
   function automatic logic [7:0] rcon(input logic [3:0] rnd);
      case (rnd)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r;
      logic [7:0] x;
      r = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) r = r ^ x;
         x = xtime(x);
      end
      return r;
   endfunction

   // S-box computed rather than tabulated: multiplicative inverse as a^254
   // (product of a^2, a^4, ..., a^128; maps 0 to 0), then the affine transform.
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] p;
      logic [7:0] inv;
      p   = a;
      inv = 8'h01;
      for (int k = 1; k < 8; k++) begin
         p   = gf_mul(p, p);
         inv = gf_mul(inv, p);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   // One MixColumns column; c[31:24] is row 0.
   function automatic logic [31:0] mix_column(input logic [31:0] c);
      logic [7:0] s0, s1, s2, s3;
      s0 = c[31:24];
      s1 = c[23:16];
      s2 = c[15:8];
      s3 = c[7:0];
      return {xtime(s0) ^ xtime(s1) ^ s1 ^ s2 ^ s3,
              s0 ^ xtime(s1) ^ xtime(s2) ^ s2 ^ s3,
              s0 ^ s1 ^ xtime(s2) ^ xtime(s3) ^ s3,
              xtime(s0) ^ s0 ^ s1 ^ s2 ^ xtime(s3)};
   endfunction

endpackage

// File: rtl/aes_round_step.sv
// ---------------------------------------------------------------------------
// aes_round_step
// Purely combinational: one AES round plus the matching key-schedule step.
//   state_i  current state (byte 0 in [127:120])
//   key_i    previous round key
//   rcon_i   round constant for this step
//   final_i  1 for the last round (MixColumns skipped)
//   state_o  next state = round(state_i, key_o)
//   key_o    next round key
// ---------------------------------------------------------------------------
module aes_round_step
   import aes_pkg::*;
(
   input  logic [127:0] state_i,
   input  logic [127:0] key_i,
   input  logic [7:0]   rcon_i,
   input  logic         final_i,
   output logic [127:0] state_o,
   output logic [127:0] key_o
);

   logic [31:0]  w0, w1, w2, w3, temp;
   logic [127:0] shifted;
   logic [127:0] mixed;

   // Key expansion: RotWord, SubWord, RCON on word 3, then ripple XOR.
   always_comb begin
      w0   = key_i[127:96];
      w1   = key_i[95:64];
      w2   = key_i[63:32];
      w3   = key_i[31:0];
      temp = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^
             {rcon_i, 24'h000000};
      key_o[127:96] = w0 ^ temp;
      key_o[95:64]  = w1 ^ w0 ^ temp;
      key_o[63:32]  = w2 ^ w1 ^ w0 ^ temp;
      key_o[31:0]   = w3 ^ w2 ^ w1 ^ w0 ^ temp;
   end

   // SubBytes + ShiftRows fused: byte (row r, col c) takes byte (r, c+r mod 4).
   always_comb begin
      shifted = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            shifted[127 - 8 * (r + 4 * c) -: 8] =
               sbox(state_i[127 - 8 * (r + 4 * ((c + r) % 4)) -: 8]);
         end
      end
   end

   always_comb begin
      mixed = '0;
      for (int c = 0; c < 4; c++) begin
         mixed[127 - 32 * c -: 32] = mix_column(shifted[127 - 32 * c -: 32]);
      end
   end

   assign state_o = (final_i ? shifted : mixed) ^ key_o;

endmodule

// File: rtl/aes128_iter_core.sv
// ---------------------------------------------------------------------------
// aes128_iter_core
// Iterative AES-128 encryptor: one round and one key-schedule step per clock,
// ten rounds per block, ciphertext on a valid/ready output channel.
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   plaintext/key channel (in_data, in_key, 128 bits each)
//   out_valid/out_ready ciphertext channel (out_data, 128 bits)
//   busy                high while a block is in ROUND or DONE
//   round_idx           current round (1..NR in ROUND, NR in DONE, 0 idle)
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; out_valid/out_data stay stable until accepted, and in_valid/in_data/
// in_key are only looked at on the transfer edge.
// ---------------------------------------------------------------------------
module aes128_iter_core
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   input  logic [127:0] in_key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy,
   output logic [3:0]   round_idx
);

   localparam logic [3:0] NR_L = 4'(NR);

   aes_state_e   state_q, state_d;
   logic [127:0] blk_q, blk_d;
   logic [127:0] key_q, key_d;
   logic [3:0]   rnd_q, rnd_d;
   logic         out_valid_q, out_valid_d;
   logic         busy_q, busy_d;

   logic [127:0] step_blk;
   logic [127:0] step_key;

   aes_round_step u_round_step (
      .state_i (blk_q),
      .key_i   (key_q),
      .rcon_i  (rcon(rnd_q)),
      .final_i (rnd_q == NR_L),
      .state_o (step_blk),
      .key_o   (step_key)
   );

   // out_ready -> in_ready is the one combinational path: a finished block can
   // be drained and the next one loaded on the same edge.
   assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);

   always_comb begin
      state_d = state_q;
      blk_d   = blk_q;
      key_d   = key_q;
      rnd_d   = rnd_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               blk_d   = in_data ^ in_key;
               key_d   = in_key;
               rnd_d   = 4'd1;
               state_d = ST_ROUND;
            end
         end
         ST_ROUND: begin
            blk_d = step_blk;
            key_d = step_key;
            // rnd stays at NR for the DONE state so it never exceeds NR.
            if (rnd_q == NR_L) state_d = ST_DONE;
            else               rnd_d   = rnd_q + 4'd1;
         end
         ST_DONE: begin
            if (out_ready) begin
               if (in_valid) begin
                  blk_d   = in_data ^ in_key;
                  key_d   = in_key;
                  rnd_d   = 4'd1;
                  state_d = ST_ROUND;
               end else begin
                  rnd_d   = 4'd0;
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            rnd_d   = 4'd0;
            state_d = ST_IDLE;
         end
      endcase
      out_valid_d = (state_d == ST_DONE);
      busy_d      = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         blk_q       <= '0;
         key_q       <= '0;
         rnd_q       <= 4'd0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         blk_q       <= blk_d;
         key_q       <= key_d;
         rnd_q       <= rnd_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign out_valid = out_valid_q;
   // Intermediate round states are not exposed on out_data.
   assign out_data  = out_valid_q ? blk_q : '0;
   assign busy      = busy_q;
   assign round_idx = rnd_q;

endmodule

// File: tb/tb_aes128_iter_core.sv
module tb_aes128_iter_core;

   localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic [127:0] in_key;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic         busy;
   logic [3:0]   round_idx;

   int checks;
   int failures;

   aes128_iter_core dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_key    (in_key),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy),
      .round_idx (round_idx)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- driver tasks ----------------
   // All tasks start and end 1 time unit after a rising edge.
   task automatic drive_accept(input logic [127:0] d, input logic [127:0] k);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_key   = k;
      while (in_ready !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < 60) begin
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_key    = '0;
      out_ready = 1'b0;
      #3;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (out_data !== 128'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (round_idx !== 4'd0) begin failures++; $display("FAIL reset_round_idx got=%0d exp=0", round_idx); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_idle got busy=%b in_ready=%b exp busy=0 in_ready=1", busy, in_ready); end
   endtask

   task automatic test_fips_c1();
      int cyc;
      out_ready = 1'b1;
      drive_accept(PT_C1, KEY_C1);
      wait_valid(cyc);
      checks++; if (cyc != 10) begin failures++; $display("FAIL c1_latency got=%0d edges exp=10", cyc); end
      checks++; if (out_data !== CT_C1) begin failures++; $display("FAIL c1_data got=%h exp=%h", out_data, CT_C1); end
      checks++; if (round_idx !== 4'd10) begin failures++; $display("FAIL c1_done_round_idx got=%0d exp=10", round_idx); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL c1_done_busy got=%b exp=1", busy); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || round_idx !== 4'd0) begin failures++; $display("FAIL c1_after_handshake got valid=%b busy=%b idx=%0d exp 0 0 0", out_valid, busy, round_idx); end
   endtask

   task automatic test_fips_b_round_walk();
      int cyc;
      out_ready = 1'b0;
      drive_accept(PT_B, KEY_B);
      for (int k = 0; k < 10; k++) begin
         checks++; if (round_idx !== 4'(k + 1) || out_valid !== 1'b0) begin failures++; $display("FAIL b_round_walk step=%0d got idx=%0d valid=%b exp idx=%0d valid=0", k, round_idx, out_valid, k + 1); end
         @(posedge clk); #1;
      end
      checks++; if (out_valid !== 1'b1 || round_idx !== 4'd10) begin failures++; $display("FAIL b_done got valid=%b idx=%0d exp valid=1 idx=10", out_valid, round_idx); end
      checks++; if (out_data !== CT_B) begin failures++; $display("FAIL b_data got=%h exp=%h", out_data, CT_B); end
      out_ready = 1'b1;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b_drain got valid=%b exp=0", out_valid); end
      cyc = 0;
   endtask

   task automatic test_back_to_back();
      logic [127:0] exp_q[$];
      logic [127:0] got_d[2];
      int           got_t[2];
      int           got;
      exp_q.push_back(CT_C1);
      exp_q.push_back(CT_B);
      got = 0;
      out_ready = 1'b1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_idle_ready got=%b exp=1", in_ready); end
      in_valid = 1'b1;
      in_data  = PT_C1;
      in_key   = KEY_C1;
      @(posedge clk); #1;
      in_data  = PT_B;
      in_key   = KEY_B;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (got == 1) in_valid = 1'b0;
         if (out_valid === 1'b1) begin
            got_d[got] = out_data;
            got_t[got] = i;
            got++;
            if (got == 2) break;
         end
      end
      in_valid = 1'b0;
      checks++; if (got != 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", got); end
      else begin
         checks++; if (got_t[0] != 10) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=10", got_t[0]); end
         checks++; if (got_t[1] - got_t[0] != 11) begin failures++; $display("FAIL b2b_spacing got=%0d exp=11", got_t[1] - got_t[0]); end
         for (int j = 0; j < 2; j++) begin
            checks++; if (got_d[j] !== exp_q[j]) begin failures++; $display("FAIL b2b_data idx=%0d got=%h exp=%h", j, got_d[j], exp_q[j]); end
         end
      end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL b2b_drain got valid=%b busy=%b exp 0 0", out_valid, busy); end
   endtask

   task automatic test_backpressure();
      int cyc;
      out_ready = 1'b0;
      drive_accept(PT_C1, KEY_C1);
      wait_valid(cyc);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_wait got valid=%b exp=1", out_valid); end
      for (int i = 0; i < 20; i++) begin
         in_valid = 1'b1;
         in_data  = {$urandom, $urandom, $urandom, $urandom};
         in_key   = {$urandom, $urandom, $urandom, $urandom};
         @(posedge clk); #1;
         checks++; if (out_valid !== 1'b1 || out_data !== CT_C1 || in_ready !== 1'b0) begin failures++; $display("FAIL bp_stall cyc=%0d got valid=%b data=%h in_ready=%b exp 1 %h 0", i, out_valid, out_data, in_ready, CT_C1); end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL bp_single_handshake got valid=%b busy=%b exp 0 0", out_valid, busy); end
   endtask

   task automatic test_reset_mid_round();
      int n;
      int seen_valid;
      int cyc;
      out_ready = 1'b1;
      drive_accept(PT_B, KEY_B);
      n = 0;
      while (round_idx !== 4'd5 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      checks++; if (round_idx !== 4'd5) begin failures++; $display("FAIL rst_mid_reach_round5 got=%0d exp=5", round_idx); end
      rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || round_idx !== 4'd0 || out_valid !== 1'b0 || out_data !== 128'h0 || in_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_outputs got busy=%b idx=%0d valid=%b data=%h in_ready=%b exp 0 0 0 0 1", busy, round_idx, out_valid, out_data, in_ready); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen_valid = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0) seen_valid++;
      end
      checks++; if (seen_valid != 0) begin failures++; $display("FAIL rst_mid_no_valid got=%0d cycles exp=0", seen_valid); end
      drive_accept(PT_C1, KEY_C1);
      wait_valid(cyc);
      checks++; if (out_data !== CT_C1 || cyc != 10) begin failures++; $display("FAIL rst_mid_next_vector got=%h lat=%0d exp=%h lat=10", out_data, cyc, CT_C1); end
      @(posedge clk); #1;
   endtask

   task automatic test_input_change_during_round();
      int cyc;
      out_ready = 1'b0;
      drive_accept(PT_B, KEY_B);
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < 60) begin
         in_valid = 1'b1;
         in_data  = {$urandom, $urandom, $urandom, $urandom};
         in_key   = {$urandom, $urandom, $urandom, $urandom};
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0;
      checks++; if (cyc != 10) begin failures++; $display("FAIL chg_latency got=%0d exp=10", cyc); end
      checks++; if (out_data !== CT_B) begin failures++; $display("FAIL chg_data got=%h exp=%h", out_data, CT_B); end
      out_ready = 1'b1;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL chg_drain got valid=%b busy=%b exp 0 0", out_valid, busy); end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_fips_c1();
      test_fips_b_round_walk();
      test_back_to_back();
      test_backpressure();
      test_reset_mid_round();
      test_input_change_during_round();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
